// File: rtl/load_unit_ms_if.sv
// Load-unit bundle: core load request/response plus data-memory req/gnt/rvalid read port.
// The slave modport is the load unit; the master modport is the core/memory environment.
interface load_unit_ms_if #(
  parameter int ADDR_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_funct3;
  logic              ld_done;
  logic [31:0]       ld_data;
  logic              ld_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  ld_valid, ld_addr, ld_funct3, mem_gnt, mem_rvalid, mem_rdata,
    output ld_ready, ld_done, ld_data, ld_err, mem_req, mem_addr
  );

  modport master (
    output ld_valid, ld_addr, ld_funct3, mem_gnt, mem_rvalid, mem_rdata,
    input  ld_ready, ld_done, ld_data, ld_err, mem_req, mem_addr
  );
endinterface

// File: rtl/load_unit_ms.sv
// Multi-cycle RV32I load unit: word-aligned memory reads, lane extraction and sign/zero
// extension, with misaligned half/word loads either split into two beats or rejected.
module load_unit_ms #(
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  load_unit_ms_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              split_q, split_d;
  logic [31:0]       lo_q, lo_d;
  logic              ld_ready_q, ld_ready_d;
  logic              ld_done_q, ld_done_d;
  logic              ld_err_q, ld_err_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [ADDR_W-1:0] word_addr;
  logic              in_legal;
  logic              in_split;

  // Shift the (possibly two-word) window down to the addressed byte, then extend.
  function automatic logic [31:0] extract(input logic [31:0] lo, input logic [31:0] hi,
                                          input logic [1:0] off, input logic [2:0] f3);
    logic [63:0] sh;
    sh = {hi, lo} >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   extract = f3[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh[31:0];
    endcase
  endfunction

  always_comb begin
    word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    in_legal  = (bus.ld_funct3 == 3'b000) || (bus.ld_funct3 == 3'b001) ||
                (bus.ld_funct3 == 3'b010) || (bus.ld_funct3 == 3'b100) ||
                (bus.ld_funct3 == 3'b101);
    in_split  = ((bus.ld_funct3[1:0] == 2'b01) && (bus.ld_addr[1:0] == 2'b11)) ||
                ((bus.ld_funct3[1:0] == 2'b10) && (bus.ld_addr[1:0] != 2'b00));

    state_d    = state_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    split_d    = split_q;
    lo_d       = lo_q;
    ld_done_d  = 1'b0;
    ld_err_d   = 1'b0;
    ld_data_d  = ld_data_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.ld_valid) begin
          addr_d  = bus.ld_addr;
          f3_d    = bus.ld_funct3;
          split_d = in_split;
          lo_d    = 32'b0;
          if (!in_legal || (in_split && !MISALIGN_EN)) begin
            state_d   = ERR;
            ld_done_d = 1'b1;
            ld_err_d  = 1'b1;
            ld_data_d = 32'b0;
          end else begin
            state_d    = REQ0;
            mem_req_d  = 1'b1;
            mem_addr_d = {bus.ld_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      REQ0: begin
        if (bus.mem_gnt) begin
          state_d   = WAIT0;
          mem_req_d = 1'b0;
        end
      end
      WAIT0: begin
        if (bus.mem_rvalid) begin
          lo_d = bus.mem_rdata;
          if (split_q) begin
            state_d    = REQ1;
            mem_req_d  = 1'b1;
            mem_addr_d = word_addr + ADDR_W'(4);
          end else begin
            state_d   = DONE;
            ld_done_d = 1'b1;
            ld_data_d = extract(bus.mem_rdata, 32'b0, addr_q[1:0], f3_q);
          end
        end
      end
      REQ1: begin
        if (bus.mem_gnt) begin
          state_d   = WAIT1;
          mem_req_d = 1'b0;
        end
      end
      WAIT1: begin
        if (bus.mem_rvalid) begin
          state_d   = DONE;
          ld_done_d = 1'b1;
          ld_data_d = extract(lo_q, bus.mem_rdata, addr_q[1:0], f3_q);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ld_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      f3_q       <= 3'b0;
      split_q    <= 1'b0;
      lo_q       <= 32'b0;
      ld_ready_q <= 1'b1;
      ld_done_q  <= 1'b0;
      ld_err_q   <= 1'b0;
      ld_data_q  <= 32'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      f3_q       <= f3_d;
      split_q    <= split_d;
      lo_q       <= lo_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
      ld_err_q   <= ld_err_d;
      ld_data_q  <= ld_data_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_err   = ld_err_q;
  assign bus.ld_data  = ld_data_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_load_unit_ms.sv
// Directed bench for load_unit_ms: one DUT with misaligned splitting, one that rejects it.
module tb_load_unit_ms;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_unit_ms_if #(.ADDR_W(32)) bm ();
  load_unit_ms_if #(.ADDR_W(32)) be ();

  load_unit_ms #(.ADDR_W(32), .MISALIGN_EN(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm));
  load_unit_ms #(.ADDR_W(32), .MISALIGN_EN(1'b0)) dut_e (.clk(clk), .rst(rst), .bus(be));

  logic [1:0]  valid_v = 2'b00;
  logic [31:0] addr_v  = 32'h0;
  logic [2:0]  f3_v    = 3'b0;
  logic        gnt_en  = 1'b1;
  logic        auto_rv = 1'b1;
  logic        stray_v = 1'b0;
  logic [31:0] stray_data = 32'h0;
  logic [1:0]  rv_q = 2'b00;
  logic [31:0] rd_q [2];
  logic [31:0] alog [2][64];
  int          acnt [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_rd = 32'hDDCC_BBAA;
      32'h0000_0104: mem_rd = 32'h4433_2211;
      32'hFFFF_FFFC: mem_rd = 32'h8765_4321;
      32'h0000_0000: mem_rd = 32'h0F0E_0D0C;
      default:       mem_rd = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bm.ld_valid   = valid_v[0];
  assign bm.ld_addr    = addr_v;
  assign bm.ld_funct3  = f3_v;
  assign bm.mem_gnt    = bm.mem_req & gnt_en;
  assign bm.mem_rvalid = rv_q[0] | stray_v;
  assign bm.mem_rdata  = stray_v ? stray_data : rd_q[0];

  assign be.ld_valid   = valid_v[1];
  assign be.ld_addr    = addr_v;
  assign be.ld_funct3  = f3_v;
  assign be.mem_gnt    = be.mem_req;
  assign be.mem_rvalid = rv_q[1];
  assign be.mem_rdata  = rd_q[1];

  initial begin
    acnt[0] = 0;
    acnt[1] = 0;
    rd_q[0] = 32'h0;
    rd_q[1] = 32'h0;
  end

  // Zero-wait memory: rvalid the cycle after the granted request; grants are logged.
  always @(posedge clk) begin
    rv_q[0] <= bm.mem_req & bm.mem_gnt & auto_rv;
    rd_q[0] <= mem_rd(bm.mem_addr);
    if (bm.mem_req && bm.mem_gnt) begin
      alog[0][acnt[0] % 64] <= bm.mem_addr;
      acnt[0] <= acnt[0] + 1;
    end
    rv_q[1] <= be.mem_req & be.mem_gnt;
    rd_q[1] <= mem_rd(be.mem_addr);
    if (be.mem_req && be.mem_gnt) begin
      alog[1][acnt[1] % 64] <= be.mem_addr;
      acnt[1] <= acnt[1] + 1;
    end
  end

  logic        o_done, o_err, o_ready;
  logic [31:0] o_data;
  logic        sel_v = 1'b0;
  assign o_done  = sel_v ? be.ld_done  : bm.ld_done;
  assign o_err   = sel_v ? be.ld_err   : bm.ld_err;
  assign o_ready = sel_v ? be.ld_ready : bm.ld_ready;
  assign o_data  = sel_v ? be.ld_data  : bm.ld_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          sel;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
    int          exp_nreq;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
  } vec_t;

  vec_t vecs[$];

  // Starts and ends just after a falling edge; a following call accepts right after ld_done.
  task automatic run_vec(input vec_t v);
    int a0;
    int lat;
    logic [31:0] d;
    logic e;
    a0 = acnt[v.sel];
    sel_v = v.sel;
    lat = -1;
    d = 32'h0;
    e = 1'b0;
    chk("ready_before_accept", {31'b0, o_ready}, 32'd1);
    addr_v = v.addr;
    f3_v = v.f3;
    valid_v[v.sel] = 1'b1;
    @(negedge clk);
    valid_v = 2'b00;
    for (int k = 1; k <= 30; k++) begin
      if (o_done) begin
        lat = k;
        d = o_data;
        e = o_err;
        break;
      end
      if (k == 1) chk("ready_low_after_accept", {31'b0, o_ready}, 32'd0);
      @(negedge clk);
    end
    $display("load dut=%0d addr=%h f3=%b data=%h err=%b lat=%0d", v.sel, v.addr, v.f3, d, e, lat);
    chk("latency", lat, v.exp_lat);
    chk("ld_data", d, v.exp_data);
    chk("ld_err", {31'b0, e}, {31'b0, v.exp_err});
    @(negedge clk);
    chk("done_one_cycle", {31'b0, o_done}, 32'd0);
    chk("ready_after_done", {31'b0, o_ready}, 32'd1);
    chk("ld_data_held", o_data, v.exp_data);
    chk("num_requests", acnt[v.sel] - a0, v.exp_nreq);
    if (v.exp_nreq >= 1) chk("mem_addr_beat0", alog[v.sel][a0 % 64], v.exp_a0);
    if (v.exp_nreq >= 2) chk("mem_addr_beat1", alog[v.sel][(a0 + 1) % 64], v.exp_a1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit seen;
    vecs.push_back('{1'b0, 32'h0000_0103, 3'b000, 32'hFFFF_FFDD, 1'b0, 3, 1, 32'h100, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0103, 3'b100, 32'h0000_00DD, 1'b0, 3, 1, 32'h100, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0102, 3'b001, 32'hFFFF_DDCC, 1'b0, 3, 1, 32'h100, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0100, 3'b101, 32'h0000_BBAA, 1'b0, 3, 1, 32'h100, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0100, 3'b010, 32'hDDCC_BBAA, 1'b0, 3, 1, 32'h100, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0101, 3'b001, 32'hFFFF_CCBB, 1'b0, 3, 1, 32'h100, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0101, 3'b101, 32'h0000_CCBB, 1'b0, 3, 1, 32'h100, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0105, 3'b000, 32'h0000_0022, 1'b0, 3, 1, 32'h104, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0106, 3'b001, 32'h0000_4433, 1'b0, 3, 1, 32'h104, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0101, 3'b010, 32'h11DD_CCBB, 1'b0, 5, 2, 32'h100, 32'h104});
    vecs.push_back('{1'b0, 32'h0000_0103, 3'b001, 32'h0000_11DD, 1'b0, 5, 2, 32'h100, 32'h104});
    vecs.push_back('{1'b0, 32'hFFFF_FFFD, 3'b010, 32'h0C87_6543, 1'b0, 5, 2, 32'hFFFF_FFFC, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0100, 3'b111, 32'h0000_0000, 1'b1, 1, 0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0102, 3'b010, 32'h0000_0000, 1'b1, 1, 0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0100, 3'b011, 32'h0000_0000, 1'b1, 1, 0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0103, 3'b101, 32'h0000_0000, 1'b1, 1, 0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0101, 3'b001, 32'hFFFF_CCBB, 1'b0, 3, 1, 32'h100, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0100, 3'b010, 32'hDDCC_BBAA, 1'b0, 3, 1, 32'h100, 32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, bm.ld_ready}, 32'd1);
    chk("rst_done", {31'b0, bm.ld_done}, 32'd0);
    chk("rst_err", {31'b0, bm.ld_err}, 32'd0);
    chk("rst_data", bm.ld_data, 32'h0);
    chk("rst_mem_req", {31'b0, bm.mem_req}, 32'd0);
    chk("rst_mem_addr", bm.mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Grant withheld in REQ0 with a stray rvalid that must not be taken as data.
    sel_v = 1'b0;
    gnt_en = 1'b0;
    addr_v = 32'h0000_0100;
    f3_v = 3'b010;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("stall_mem_req", {31'b0, bm.mem_req}, 32'd1);
      chk("stall_mem_addr", bm.mem_addr, 32'h100);
      chk("stall_ready", {31'b0, bm.ld_ready}, 32'd0);
      chk("stall_done", {31'b0, bm.ld_done}, 32'd0);
      stray_v = (i == 1);
      stray_data = 32'h1234_5678;
      @(negedge clk);
    end
    stray_v = 1'b0;
    chk("stall_mem_req_end", {31'b0, bm.mem_req}, 32'd1);
    gnt_en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bm.ld_done) begin
        seen = 1'b1;
        $display("stall load data=%h err=%b wait=%0d", bm.ld_data, bm.ld_err, k);
        chk("stall_wait", k, 2);
        chk("stall_data", bm.ld_data, 32'hDDCC_BBAA);
        chk("stall_err", {31'b0, bm.ld_err}, 32'd0);
        break;
      end
      @(negedge clk);
    end
    chk("stall_done_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);

    // Reset while waiting for read data; the late response must be dropped.
    auto_rv = 1'b0;
    addr_v = 32'h0000_0100;
    f3_v = 3'b010;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v = 2'b00;
    @(negedge clk);
    chk("wait0_mem_req", {31'b0, bm.mem_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset in WAIT0 ready=%b done=%b data=%h", bm.ld_ready, bm.ld_done, bm.ld_data);
    chk("mid_rst_ready", {31'b0, bm.ld_ready}, 32'd1);
    chk("mid_rst_done", {31'b0, bm.ld_done}, 32'd0);
    chk("mid_rst_err", {31'b0, bm.ld_err}, 32'd0);
    chk("mid_rst_data", bm.ld_data, 32'h0);
    chk("mid_rst_mem_req", {31'b0, bm.mem_req}, 32'd0);
    chk("mid_rst_mem_addr", bm.mem_addr, 32'h0);
    stray_v = 1'b1;
    stray_data = 32'hDDCC_BBAA;
    @(negedge clk);
    stray_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rvalid_no_done", {31'b0, bm.ld_done}, 32'd0);
      @(negedge clk);
    end
    auto_rv = 1'b1;
    v = '{1'b0, 32'h0000_0104, 3'b010, 32'h4433_2211, 1'b0, 3, 1, 32'h104, 32'h0};
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_unit_ms.md
Name: load_unit_ms

Overview:
Multi-cycle RV32I load unit and the successor to the single-byte extender. It accepts a load request from the core and issues word-aligned read(s) to data memory over a req/gnt/rvalid handshake. It extracts the byte, half or word lanes and sign- or zero-extends the result per funct3. Misaligned halfword/word loads either split into two memory beats or raise an error, selected by parameter.

Parameters:
ADDR_W, 32, byte-address width of ld_addr and mem_addr
MISALIGN_EN, 1, 1: misaligned LH/LHU/LW split into two beats; 0: misaligned load flagged as error with no memory access

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ld_valid  in  1  core load request
ld_ready  out  1  unit idle and able to accept; high only in IDLE
ld_addr  in  ADDR_W  byte address, sampled on accept
ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
ld_done  out  1  one-cycle completion pulse
ld_data  out  32  extended result, valid with ld_done, held until next ld_done
ld_err  out  1  pulses with ld_done on illegal funct3 or disallowed misalignment
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  word address, bits [1:0] always 0
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data, little-endian byte lanes

Behaviour:
- Reset values: state IDLE, ld_ready 1, ld_done 0, ld_err 0, ld_data 0, mem_req 0, mem_addr 0, internal buffers 0.
- Accept: when ld_valid && ld_ready, latch ld_addr (A) and ld_funct3. Sample nothing while busy.
- Decode at accept:
  - split = (LH/LHU && A[1:0]==3) || (LW && A[1:0]!=0).
  - LB/LBU never split.
  - An illegal funct3, or split with MISALIGN_EN=0, goes to ERR.
- States:
  - IDLE: go to REQ0, or to ERR.
  - REQ0: mem_req=1, mem_addr={A[ADDR_W-1:2],00}. Hold mem_req and mem_addr stable until mem_gnt. On gnt go to WAIT0.
  - WAIT0: mem_req=0. On mem_rvalid capture lo=mem_rdata, then go to REQ1 if split, else to DONE.
  - REQ1: mem_req=1, mem_addr = word address + 4, wrapping mod 2^ADDR_W. On gnt go to WAIT1.
  - WAIT1: on mem_rvalid capture hi=mem_rdata, go to DONE.
  - DONE: ld_done=1 for exactly one cycle, ld_data updated, go to IDLE.
  - ERR: ld_done=1, ld_err=1, ld_data=0 for one cycle, go to IDLE. No mem_req is issued.
- mem_rvalid is ignored outside WAIT0/WAIT1, including the same cycle as gnt and any stray or late response in IDLE.
- Extraction:
  - Form the 64-bit value {hi,lo}, with hi=0 when not split, and shift right by 8*A[1:0].
  - Take bits [7:0] for B, [15:0] for H, [31:0] for W.
  - funct3[2]=0: sign-extend from the MSB of the selected field. funct3[2]=1: zero-extend.
- Latency with zero-wait memory (gnt in the REQ cycle, rvalid the cycle after):
  - Aligned: ld_done 3 cycles after the accept cycle.
  - Split: 5 cycles.
  - ERR: 1 cycle.
- ld_ready falls the cycle after accept and returns high the cycle after ld_done.
- A new accept may occur in the cycle immediately after ld_done.
- Reset mid-operation (any state): next cycle is IDLE with reset values. The outstanding transaction is dropped, no ld_done is produced, and late rvalid is ignored.

Test Plan:
- Memory: word 0x100 = 0xDDCCBBAA, word 0x104 = 0x44332211, gnt immediate, rvalid next cycle.
- LB at 0x103 -> single mem_addr 0x100; ld_data=0xFFFFFFDD with ld_done 3 cycles after accept. LBU at 0x103 -> 0x000000DD.
- LH at 0x102 -> 0xFFFFDDCC. LHU at 0x100 -> 0x0000BBAA. LW at 0x100 -> 0xDDCCBBAA. All: one mem_req, ld_err=0.
- MISALIGN_EN=1, LW at 0x101:
  - Two requests, mem_addr 0x100 then 0x104; ld_data=0x11DDCCBB; ld_done 5 cycles after accept.
  - LH at 0x103 -> 0x000011DD.
  - LW at 0xFFFFFFFD with ADDR_W=32 -> second mem_addr wraps to 0x00000000.
- MISALIGN_EN=0, LW at 0x102 -> no mem_req; ld_done=ld_err=1 one cycle after accept; ld_data=0. funct3=011 at 0x100 -> same error response.
- Hold mem_gnt low 4 cycles in REQ0 -> mem_req and mem_addr stable throughout, ld_ready=0. Stray rvalid during REQ0 is ignored, and result is unchanged once the correct rvalid arrives.
- Assert rst for 1 cycle during WAIT0 -> next cycle IDLE, ld_ready=1, all outputs at reset values. A subsequent rvalid produces no ld_done, and the next LW at 0x104 returns 0x44332211.
